dispatch_controller: RTL
========================

DISPATCH_CONTROLLER -- requirements
Module: dispatch_controller

Interface
REQ-001 Parameter OPCODE_W, default 8, SHALL set the opcode width (legal range >= 4).
REQ-002 Parameter NUM_UNITS, default 2, SHALL set the number of ALU units (legal range 1..8).
REQ-003 Parameter MUL_LAT, default 3, SHALL set the MUL unit occupancy in cycles (>= 1).
REQ-004 Parameter DIV_LAT, default 8, SHALL set the DIV/MOD unit occupancy in cycles (>= 1).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-007 in_valid  input  1  SHALL flag a valid instruction on in_opcode.
REQ-008 in_opcode  input  OPCODE_W  SHALL carry the instruction opcode.
REQ-009 in_ready  output  1  SHALL flag that an instruction can be accepted this cycle.
REQ-010 issue_valid  output  1  SHALL pulse for one cycle per issued instruction.
REQ-011 issue_op  output  4  SHALL carry the decoded ula_operation code of the issue.
REQ-012 issue_unit  output  NUM_UNITS  SHALL be the one-hot target unit of the issue.
REQ-013 unit_busy  output  NUM_UNITS  SHALL flag each unit with a nonzero occupancy counter.
REQ-014 retire  output  NUM_UNITS  SHALL pulse for the last occupancy cycle of each unit.
REQ-015 illegal  output  1  SHALL pulse for one cycle per accepted illegal opcode.
REQ-016 illegal_count  output  8  SHALL count accepted illegal opcodes, saturating at 255.

Function
REQ-017 Decode SHALL map opcode 0x01..0x0C to op 0x1..0xC, 0x0E to 0xE and 0x0F to 0xF; every other value (0x00, 0x0D, > 0x0F) SHALL be illegal.
REQ-018 Occupancy SHALL be MUL_LAT for op 0x3, DIV_LAT for op 0x4/0x5, and 1 for all other legal ops.
REQ-019 Each unit SHALL hold a down-counter cnt; a unit SHALL be available when cnt <= 1.
REQ-020 in_ready SHALL be high when at least one unit is available, derived from registered state only.
REQ-021 Acceptance SHALL occur in the cycle where in_valid and in_ready are both high; in_opcode SHALL be ignored otherwise.
REQ-022 A legal instruction accepted in cycle T SHALL select the first available unit at or after the round-robin pointer (wrapping), load its cnt with the occupancy, and advance the pointer to the selected unit + 1 modulo NUM_UNITS.
REQ-023 For that instruction, issue_valid, issue_op and issue_unit SHALL be presented in cycle T+1; unit_busy SHALL be high from T+1 for exactly occupancy cycles, with retire high in the last of them.
REQ-024 A unit whose cnt == 1 SHALL be reselectable in the same cycle; the new load SHALL override the decrement, and retire SHALL still pulse for the finishing instruction.
REQ-025 A non-loaded unit with nonzero cnt SHALL decrement by 1 each cycle; cnt == 0 SHALL hold.
REQ-026 An accepted illegal opcode SHALL consume no unit, leave the pointer unchanged, drive issue_valid low, and pulse illegal in T+1 while incrementing illegal_count (saturating).
REQ-027 When issue_valid is low, issue_op and issue_unit SHALL be 0.
REQ-028 At most one instruction SHALL be accepted per cycle.

Reset
REQ-029 While rst_n is low at a clock edge, all cnt, pointer, issue_valid, issue_op, issue_unit, retire, illegal and illegal_count SHALL clear to 0; in_ready SHALL then be 1.
REQ-030 Reset mid-operation SHALL abort all occupancy with no retire pulse for the aborted instructions.

Verification
REQ-031 NUM_UNITS=2: ADD (0x01) accepted at T -> issue_valid=1, issue_op=0x1, issue_unit=01 at T+1; retire=01 at T+1; unit 0 free at T+2.
REQ-032 Back-to-back DIV, DIV, ADD -> units 01 then 10 each busy 8 cycles; in_ready=0 until unit 0 cnt reaches 1; ADD issues to unit 01 in the cycle after unit 0's retire.
REQ-033 Opcode 0x0D then 0x20 -> illegal pulses twice, illegal_count=2, no issue_valid, pointer unchanged.
REQ-034 256 illegal opcodes -> illegal_count saturates at 255.
REQ-035 MUL accepted, rst_n low 1 cycle at T+2 -> unit_busy=0, retire never pulses, in_ready=1 after reset.
REQ-036 in_valid=1 with in_ready=0 -> no acceptance, no issue, no illegal, state unchanged.

Source files
------------

// File: rtl/dispatch_controller.sv
// Instruction dispatcher: decodes opcodes, issues them round-robin onto NUM_UNITS
// ALU units with per-unit occupancy counters, and counts illegal opcodes.
module dispatch_controller #(
    parameter int OPCODE_W  = 8,
    parameter int NUM_UNITS = 2,
    parameter int MUL_LAT   = 3,
    parameter int DIV_LAT   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [OPCODE_W-1:0]  in_opcode,
    output logic                 in_ready,
    output logic                 issue_valid,
    output logic [3:0]           issue_op,
    output logic [NUM_UNITS-1:0] issue_unit,
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic [NUM_UNITS-1:0] retire,
    output logic                 illegal,
    output logic [7:0]           illegal_count
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int PTR_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int EXT_W   = OPCODE_W + 1;

    // Handshake: an instruction is accepted in any cycle where in_valid and
    // in_ready are both high; in_ready depends only on registered counters.

    logic [CNT_W-1:0]     cnt [NUM_UNITS];
    logic [PTR_W-1:0]     ptr;
    logic [NUM_UNITS-1:0] avail;
    logic                 legal;
    logic [3:0]           dec_op;
    logic [CNT_W-1:0]     occ;
    logic                 accept;
    logic                 take;
    logic                 bad;
    logic [PTR_W-1:0]     sel_idx;
    logic [NUM_UNITS-1:0] sel_onehot;
    logic                 sel_found;
    int                   idx;

    always_comb begin
        dec_op = in_opcode[3:0];
        legal  = ({1'b0, in_opcode} < EXT_W'(16)) && (dec_op != 4'h0) && (dec_op != 4'hD);
        case (dec_op)
            4'h3:       occ = CNT_W'(MUL_LAT);
            4'h4, 4'h5: occ = CNT_W'(DIV_LAT);
            default:    occ = CNT_W'(1);
        endcase
    end

    // A unit finishing this cycle (cnt == 1) already counts as available.
    always_comb begin
        avail     = '0;
        unit_busy = '0;
        retire    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            avail[i]     = (cnt[i] <= CNT_W'(1));
            unit_busy[i] = (cnt[i] != '0);
            retire[i]    = (cnt[i] == CNT_W'(1));
        end
    end

    assign in_ready = |avail;
    assign accept   = in_valid && in_ready;
    assign take     = accept && legal;
    assign bad      = accept && !legal;

    // First available unit at or after the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
            if (!sel_found && avail[idx]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(idx);
            end
        end
        sel_onehot = NUM_UNITS'(1) << sel_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) cnt[i] <= '0;
            ptr           <= '0;
            issue_valid   <= 1'b0;
            issue_op      <= 4'h0;
            issue_unit    <= '0;
            illegal       <= 1'b0;
            illegal_count <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (take && sel_onehot[i]) cnt[i] <= occ;
                else if (cnt[i] != '0)     cnt[i] <= cnt[i] - CNT_W'(1);
            end
            if (take) begin
                if (sel_idx == PTR_W'(NUM_UNITS - 1)) ptr <= '0;
                else                                  ptr <= sel_idx + PTR_W'(1);
            end
            issue_valid <= take;
            issue_op    <= take ? dec_op : 4'h0;
            issue_unit  <= take ? sel_onehot : '0;
            illegal     <= bad;
            if (bad && illegal_count != 8'hFF) illegal_count <= illegal_count + 8'h01;
        end
    end
endmodule
